// File: rtl/mp_cmd_sched_if.sv
// rtl/mp_cmd_sched_if.sv - request/offer bundle between mp mailboxes, scheduler and core thread schedulers
interface mp_cmd_sched_if #(
  parameter int PC_W   = 14,
  parameter int DATA_W = 32
);
  logic [15:0]          req_valid;
  logic [16*PC_W-1:0]   req_pc;
  logic [16*DATA_W-1:0] req_data;
  logic [15:0]          req_ack;
  logic [3:0]           mp_access;
  logic [3:0]           mp_access_ack;
  logic [4*PC_W-1:0]    mp_command_pc_out;
  logic [4*DATA_W-1:0]  mp_command_data_out;
  logic [7:0]           grant_src;
  logic [3:0]           timeout_flag;

  modport master (
    input  req_valid, req_pc, req_data, mp_access_ack,
    output req_ack, mp_access, mp_command_pc_out, mp_command_data_out, grant_src, timeout_flag
  );

  modport slave (
    output req_valid, req_pc, req_data, mp_access_ack,
    input  req_ack, mp_access, mp_command_pc_out, mp_command_data_out, grant_src, timeout_flag
  );
endinterface

// File: rtl/mp_cmd_sched.sv
// rtl/mp_cmd_sched.sv - per-destination round-robin command scheduler for the 4-core mp fabric
// Optional offer watchdog enabled by defining MP_SCHED_TIMEOUT_EN.
module mp_cmd_sched #(
  parameter int NCORE   = 4,
  parameter int PC_W    = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rstn,
  mp_cmd_sched_if.master bus
);
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  if (NCORE != 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mp_cmd_sched: NCORE must be 4 and TIMEOUT 1..255");
  end

  for (genvar d = 0; d < 4; d++) begin : g_dst
    localparam logic [1:0] D2 = 2'(d);

    state_t              state_q, state_d;
    logic [1:0]          last_q, grant_q, pick;
    logic                pick_ok, ack_hit, withdraw, expire, access_o;
    logic [3:0]          ack_col;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   data_q;

    assign ack_hit  = (state_q == OFFER) && bus.mp_access_ack[d];
    assign withdraw = (state_q == OFFER) && !bus.req_valid[{grant_q, D2}];

    // Scan last+4 down to last+1 so the nearest eligible source after last_q wins.
    always_comb begin : arb
      logic [1:0] cand;
      cand    = last_q;
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = 4; i >= 1; i--) begin
        cand = last_q + 2'(i);
        if (bus.req_valid[{cand, D2}] && cand != D2) begin
          pick    = cand;
          pick_ok = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        last_q  <= 2'd3;
        grant_q <= '0;
        pc_q    <= '0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        if (state_q == IDLE && pick_ok) begin
          grant_q <= pick;
          pc_q    <= bus.req_pc[int'({pick, D2}) * PC_W +: PC_W];
          data_q  <= bus.req_data[int'({pick, D2}) * DATA_W +: DATA_W];
        end
        if (ack_hit || expire) last_q <= grant_q;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (pick_ok) state_d = OFFER;
        OFFER:   if (ack_hit || withdraw || expire) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      access_o = (state_q == OFFER);
      ack_col  = '0;
      if (ack_hit) ack_col[grant_q] = 1'b1;
    end

    for (genvar s = 0; s < 4; s++) begin : g_ack
      assign bus.req_ack[s*4+d] = ack_col[s];
    end

    assign bus.mp_access[d]                              = access_o;
    assign bus.mp_command_pc_out[d*PC_W +: PC_W]         = pc_q;
    assign bus.mp_command_data_out[d*DATA_W +: DATA_W]   = data_q;
    assign bus.grant_src[d*2 +: 2]                       = grant_q;

`ifdef MP_SCHED_TIMEOUT_EN
    logic [7:0] wait_q;
    logic       flag_q;

    // Ack and withdrawal both take precedence over abandoning the offer.
    assign expire = (state_q == OFFER) && !bus.mp_access_ack[d] &&
                    bus.req_valid[{grant_q, D2}] && (wait_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wait_q <= '0;
        flag_q <= 1'b0;
      end else begin
        flag_q <= expire;
        if (state_q != OFFER) wait_q <= '0;
        else if (!bus.mp_access_ack[d]) wait_q <= wait_q + 8'd1;
      end
    end

    assign bus.timeout_flag[d] = flag_q;
`else
    assign expire              = 1'b0;
    assign bus.timeout_flag[d] = 1'b0;
`endif
  end
endmodule
